effect_ram_responder: RTL and testbench
=======================================

EFFECT_RAM_RESPONDER -- requirements
Module: effect_ram_responder

Interface
REQ-001 SHALL have parameter RING_BASE, default 7, meaning first physical ring-buffer address.
REQ-002 SHALL have parameter RING_DEPTH, default 1024, meaning number of 32-bit ring words stored (addresses RING_BASE..RING_BASE+RING_DEPTH-1).
REQ-003 SHALL have parameter OUT_ADDR, default 15'h7FFF, meaning processed-sample output address.
REQ-004 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port loc_ramaddress  in  15  initiator word address.
REQ-007 SHALL have port loc_ramclk  in  1  initiator access strobe (level, generated in clk domain).
REQ-008 SHALL have ports loc_ramread and loc_ramwrite  in  1 each  initiator read and write qualifiers.
REQ-009 SHALL have port loc_writedata  in  32  initiator write data.
REQ-010 SHALL have port loc_readdata  out  32  read data to initiator.
REQ-011 SHALL have ports host_wr_en  in  1, host_wr_addr  in  3, and host_wr_data  in  32, forming the host configuration write port.
REQ-012 SHALL have ports sample_valid  in  1 and sample_data  in  16, carrying incoming audio samples.
REQ-013 SHALL have port sample_ready  out  1  sample accept.
REQ-014 SHALL have port wr_ptr  out  15  next ring address to be written.
REQ-015 SHALL have ports out_sample  out  16 and out_valid  out  1, carrying the processed sample and its one-cycle valid pulse.
REQ-016 SHALL have port overrun  out  1  sticky dropped-sample flag.

Function
REQ-017 SHALL hold config registers cfg[0..6], 32 bits each; host_wr_en with host_wr_addr 0-6 writes cfg[addr] on the next edge.
REQ-018 SHALL treat host_wr_en with host_wr_addr 7 as a clear-overrun command; nothing is stored.
REQ-019 SHALL supply read data combinationally: when loc_ramread=1, loc_readdata = cfg[addr] for addr 0-6, ring word for ring addresses, {16'h0,out_sample} for OUT_ADDR, and 0 otherwise; when loc_ramread=0, loc_readdata = 0 (zero-latency, so the initiator samples it one cycle after raising loc_ramclk).
REQ-020 SHALL register loc_ramclk and detect a strobe as current=1 and previous=0; one strobe is exactly one access.
REQ-021 SHALL, on a strobe with loc_ramwrite=1 to OUT_ADDR, load out_sample <= loc_writedata[15:0] and pulse out_valid high for exactly one cycle.
REQ-022 SHALL, on a strobe with loc_ramwrite=1 to a ring address, write loc_writedata to that ring word.
REQ-023 SHALL ignore initiator writes to addresses 0-6 and to unmapped addresses.
REQ-024 SHALL take ring wrap bounds from cfg[0]: first = cfg[0][16:2] and last = cfg[0][31:17]; if first > last, or either bound is outside the physical ring, the bounds SHALL be RING_BASE..RING_BASE+RING_DEPTH-1.
REQ-025 SHALL accept a sample when sample_valid=1 and sample_ready=1, write {16'h0,sample_data} to ring[wr_ptr] on the same edge, and advance wr_ptr by 1.
REQ-026 SHALL wrap wr_ptr from last back to first in the same cycle.
REQ-027 SHALL deassert sample_ready combinationally in any cycle where a strobe-qualified initiator ring write is detected; the initiator write wins that cycle.
REQ-028 SHALL otherwise hold sample_ready=1 whenever not in reset.
REQ-029 SHALL set overrun (sticky) when sample_valid=1 and sample_ready=0, because the audio source does not stall and the sample is lost.
REQ-030 SHALL give a clear-overrun command priority below a same-cycle set, so overrun stays 1.
REQ-031 SHALL reload wr_ptr to the new effective first bound on the edge after a host write to cfg[0], discarding any same-cycle sample advance; the sample itself is still written at the old wr_ptr.
REQ-032 SHALL return the pre-write value for an initiator read of a ring word being written by a sample in the same cycle.

Reset
REQ-033 SHALL, while reset=1, force cfg[0..6]=0, out_sample=0, out_valid=0, overrun=0, wr_ptr=RING_BASE, sample_ready=0, and the strobe history register to 0.
REQ-034 SHALL leave ring contents unreset; a reset mid-access SHALL cancel the access, and no strobe SHALL be detected on the first edge after release unless loc_ramclk rises then.

Verification
REQ-035 Bench SHALL cover: host writes cfg[1]=32'h0000_0040, then the initiator raises loc_ramclk with loc_ramread=1 and address 1 -> loc_readdata=32'h40 in that same cycle and the next.
REQ-036 Bench SHALL cover: cfg[0]={15'd10,15'd7,2'b01} and 5 samples 0x1111..0x5555 -> ring 7,8,9,10,7 hold 0x1111,0x2222,0x3333,0x4444,0x5555, and wr_ptr=8.
REQ-037 Bench SHALL cover: an initiator strobe write of 32'h0000_ABCD to 15'h7FFF -> out_sample=16'hABCD with a single-cycle out_valid pulse; loc_ramclk held high for 3 cycles produces only one pulse.
REQ-038 Bench SHALL cover: an initiator ring write coinciding with sample_valid -> sample_ready=0, overrun=1, the initiator data stored, and wr_ptr unchanged; a host write to addr 7 then gives overrun=0.
REQ-039 Bench SHALL cover: cfg[0] with first=20 and last=12 -> wrap uses 7..1030 and wr_ptr reloads to 7.
REQ-040 Bench SHALL cover: reset asserted mid-stream -> all outputs at their reset values immediately (asynchronously), and wr_ptr=7 after release.

Source files
------------

// File: rtl/effect_ram_if.sv
// Initiator-side RAM bus shared by the effect processor and the responder.
interface effect_ram_if;
    logic [14:0] loc_ramaddress;
    logic        loc_ramclk;
    logic        loc_ramread;
    logic        loc_ramwrite;
    logic [31:0] loc_writedata;
    logic [31:0] loc_readdata;

    modport master (
        output loc_ramaddress, loc_ramclk, loc_ramread, loc_ramwrite, loc_writedata,
        input  loc_readdata
    );
    modport slave (
        input  loc_ramaddress, loc_ramclk, loc_ramread, loc_ramwrite, loc_writedata,
        output loc_readdata
    );
endinterface

// File: rtl/effect_ram_responder.sv
// Memory-mapped responder: config registers, a sample ring buffer fed by an
// audio source, and a processed-sample output register for the effect initiator.
module effect_ram_responder #(
    parameter int          RING_BASE  = 7,
    parameter int          RING_DEPTH = 1024,
    parameter logic [14:0] OUT_ADDR   = 15'h7FFF
) (
    input  logic              clk,
    input  logic              reset,
    effect_ram_if.slave       bus,
    input  logic              host_wr_en,
    input  logic [2:0]        host_wr_addr,
    input  logic [31:0]       host_wr_data,
    input  logic              sample_valid,
    input  logic [15:0]       sample_data,
    output logic              sample_ready,
    output logic [14:0]       wr_ptr,
    output logic [15:0]       out_sample,
    output logic              out_valid,
    output logic              overrun
);
    localparam int          IDX_W   = (RING_DEPTH > 1) ? $clog2(RING_DEPTH) : 1;
    localparam logic [14:0] P_FIRST = 15'(RING_BASE);
    localparam logic [14:0] P_LAST  = 15'(RING_BASE + RING_DEPTH - 1);

    logic [31:0] r_cfg [0:6];
    logic [31:0] r_ring [0:RING_DEPTH-1];
    logic        r_strobe_prev;
    logic [14:0] r_wr_ptr;
    logic [15:0] r_out_sample;
    logic        r_out_valid;
    logic        r_overrun;

    logic        w_strobe;
    logic        w_is_ring;
    logic        w_init_ring_wr;
    logic        w_out_wr;
    logic        w_accept;
    logic        w_cfg0_wr;
    logic        w_clr_overrun;
    logic [14:0] w_first;
    logic [14:0] w_last;
    logic [31:0] w_rdata;

    // A bound pair is only trusted if ordered and fully inside the physical ring.
    function automatic logic bounds_ok(input logic [31:0] c);
        return (c[16:2] <= c[31:17]) && (c[16:2] >= P_FIRST) && (c[31:17] <= P_LAST);
    endfunction

    function automatic logic [14:0] eff_first(input logic [31:0] c);
        return bounds_ok(c) ? c[16:2] : P_FIRST;
    endfunction

    function automatic logic [14:0] eff_last(input logic [31:0] c);
        return bounds_ok(c) ? c[31:17] : P_LAST;
    endfunction

    function automatic logic [IDX_W-1:0] ring_idx(input logic [14:0] a);
        logic [14:0] off;
        off = a - P_FIRST;
        return off[IDX_W-1:0];
    endfunction

    assign w_strobe       = bus.loc_ramclk & ~r_strobe_prev & ~reset;
    assign w_is_ring      = (bus.loc_ramaddress >= P_FIRST) && (bus.loc_ramaddress <= P_LAST);
    assign w_init_ring_wr = w_strobe & bus.loc_ramwrite & w_is_ring;
    assign w_out_wr       = w_strobe & bus.loc_ramwrite & (bus.loc_ramaddress == OUT_ADDR);
    assign sample_ready   = ~reset & ~w_init_ring_wr;
    assign w_accept       = sample_valid & sample_ready;
    assign w_cfg0_wr      = host_wr_en & (host_wr_addr == 3'd0);
    assign w_clr_overrun  = host_wr_en & (host_wr_addr == 3'd7);
    assign w_first        = eff_first(r_cfg[0]);
    assign w_last         = eff_last(r_cfg[0]);

    always_comb begin
        w_rdata = '0;
        if (bus.loc_ramread) begin
            if (bus.loc_ramaddress < 15'd7)
                w_rdata = r_cfg[bus.loc_ramaddress[2:0]];
            else if (w_is_ring)
                w_rdata = r_ring[ring_idx(bus.loc_ramaddress)];
            else if (bus.loc_ramaddress == OUT_ADDR)
                w_rdata = {16'h0, r_out_sample};
        end
    end

    assign bus.loc_readdata = w_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 7; i++) r_cfg[i] <= '0;
            r_strobe_prev <= 1'b0;
            r_wr_ptr      <= P_FIRST;
            r_out_sample  <= '0;
            r_out_valid   <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_strobe_prev <= bus.loc_ramclk;
            if (host_wr_en && host_wr_addr != 3'd7)
                r_cfg[host_wr_addr] <= host_wr_data;
            // A new cfg[0] restarts the ring; the coincident sample still lands at the old pointer.
            if (w_cfg0_wr)
                r_wr_ptr <= eff_first(host_wr_data);
            else if (w_accept)
                r_wr_ptr <= (r_wr_ptr >= w_last) ? w_first : r_wr_ptr + 15'd1;
            r_out_valid <= w_out_wr;
            if (w_out_wr)
                r_out_sample <= bus.loc_writedata[15:0];
            if (sample_valid && !sample_ready)
                r_overrun <= 1'b1;
            else if (w_clr_overrun)
                r_overrun <= 1'b0;
        end
    end

    // Ring storage is not reset; the initiator write and a sample write never coincide.
    always_ff @(posedge clk) begin
        if (w_init_ring_wr)
            r_ring[ring_idx(bus.loc_ramaddress)] <= bus.loc_writedata;
        else if (w_accept)
            r_ring[ring_idx(r_wr_ptr)] <= {16'h0, sample_data};
    end

    assign wr_ptr     = r_wr_ptr;
    assign out_sample = r_out_sample;
    assign out_valid  = r_out_valid;
    assign overrun    = r_overrun;
endmodule

// File: tb/tb_effect_ram_responder.sv
// Scenario bench for effect_ram_responder with a scoreboard for output pulses and ring contents.
module tb_effect_ram_responder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        host_wr_en = 1'b0;
    logic [2:0]  host_wr_addr = '0;
    logic [31:0] host_wr_data = '0;
    logic        sample_valid = 1'b0;
    logic [15:0] sample_data = '0;
    logic        sample_ready;
    logic [14:0] wr_ptr;
    logic [15:0] out_sample;
    logic        out_valid;
    logic        overrun;

    effect_ram_if bus();

    effect_ram_responder dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .host_wr_en   (host_wr_en),
        .host_wr_addr (host_wr_addr),
        .host_wr_data (host_wr_data),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .sample_ready (sample_ready),
        .wr_ptr       (wr_ptr),
        .out_sample   (out_sample),
        .out_valid    (out_valid),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int pulse_cnt = 0;
    logic [15:0] exp_q[$];
    logic [14:0] ring_addr_q[$];
    logic [31:0] ring_data_q[$];

    // Every out_valid pulse must match the next queued expected sample.
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            pulse_cnt++;
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL out_pulse: unexpected pulse with out_sample=%h, required no pulse", out_sample);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (out_sample !== e)
                    $display("FAIL out_pulse: out_sample=%h, required %h", out_sample, e);
                else
                    n_pass++;
            end
        end
    end

    task automatic host_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        host_wr_en = 1'b1; host_wr_addr = a; host_wr_data = d;
        @(negedge clk);
        host_wr_en = 1'b0;
    endtask

    task automatic peek(input logic [14:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.loc_ramaddress = a; bus.loc_ramread = 1'b1;
        #1 d = bus.loc_readdata;
        bus.loc_ramread = 1'b0;
    endtask

    task automatic check_ring_q(input string name);
        logic [31:0] d;
        while (ring_addr_q.size() > 0) begin
            logic [14:0] a;
            logic [31:0] e;
            a = ring_addr_q.pop_front();
            e = ring_data_q.pop_front();
            peek(a, d);
            n_checks++;
            if (d !== e) $display("FAIL %s: ring[%0d]=%h, required %h", name, a, d, e);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        bus.loc_ramaddress = '0; bus.loc_ramclk = 1'b0; bus.loc_ramread = 1'b0;
        bus.loc_ramwrite = 1'b0; bus.loc_writedata = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (wr_ptr !== 15'd7) $display("FAIL rst_wr_ptr: %0d, required 7", wr_ptr); else n_pass++;
        n_checks++; if (sample_ready !== 1'b0) $display("FAIL rst_ready: %b, required 0", sample_ready); else n_pass++;
        n_checks++; if (overrun !== 1'b0) $display("FAIL rst_overrun: %b, required 0", overrun); else n_pass++;
        n_checks++; if (out_valid !== 1'b0 || out_sample !== 16'h0)
            $display("FAIL rst_out: valid=%b sample=%h, required 0/0000", out_valid, out_sample); else n_pass++;
        bus.loc_ramread = 1'b1; bus.loc_ramaddress = 15'd0;
        #1;
        n_checks++; if (bus.loc_readdata !== 32'h0) $display("FAIL rst_cfg0: %h, required 0", bus.loc_readdata); else n_pass++;
        bus.loc_ramread = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++; if (sample_ready !== 1'b1) $display("FAIL ready_after_rst: %b, required 1", sample_ready); else n_pass++;
    endtask

    task automatic test_cfg_read();
        host_write(3'd1, 32'h0000_0040);
        @(negedge clk);
        bus.loc_ramaddress = 15'd1; bus.loc_ramread = 1'b1; bus.loc_ramclk = 1'b1;
        #1;
        n_checks++; if (bus.loc_readdata !== 32'h40) $display("FAIL cfg1_read_c0: %h, required 00000040", bus.loc_readdata); else n_pass++;
        @(negedge clk);
        n_checks++; if (bus.loc_readdata !== 32'h40) $display("FAIL cfg1_read_c1: %h, required 00000040", bus.loc_readdata); else n_pass++;
        bus.loc_ramclk = 1'b0; bus.loc_ramread = 1'b0;
    endtask

    task automatic test_ring_wrap();
        host_write(3'd0, {15'd10, 15'd7, 2'b01});
        n_checks++; if (wr_ptr !== 15'd7) $display("FAIL wrap_reload: %0d, required 7", wr_ptr); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            sample_valid = 1'b1; sample_data = 16'h1111 * 16'(i + 1);
        end
        @(negedge clk);
        sample_valid = 1'b0;
        n_checks++; if (wr_ptr !== 15'd8) $display("FAIL wrap_wr_ptr: %0d, required 8", wr_ptr); else n_pass++;
        ring_addr_q.push_back(15'd7);  ring_data_q.push_back(32'h5555);
        ring_addr_q.push_back(15'd8);  ring_data_q.push_back(32'h2222);
        ring_addr_q.push_back(15'd9);  ring_data_q.push_back(32'h3333);
        ring_addr_q.push_back(15'd10); ring_data_q.push_back(32'h4444);
        check_ring_q("wrap_ring");
    endtask

    task automatic test_out_write();
        pulse_cnt = 0;
        exp_q.push_back(16'hABCD);
        @(negedge clk);
        bus.loc_ramaddress = 15'h7FFF; bus.loc_ramwrite = 1'b1;
        bus.loc_writedata = 32'h0000_ABCD; bus.loc_ramclk = 1'b1;
        repeat (3) @(negedge clk);
        bus.loc_ramclk = 1'b0; bus.loc_ramwrite = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (pulse_cnt !== 1) $display("FAIL out_pulse_count: %0d, required 1", pulse_cnt); else n_pass++;
        n_checks++; if (exp_q.size() !== 0) $display("FAIL out_pulse_missing: %0d pending, required 0", exp_q.size()); else n_pass++;
        n_checks++; if (out_sample !== 16'hABCD) $display("FAIL out_sample_hold: %h, required abcd", out_sample); else n_pass++;
    endtask

    task automatic test_collision();
        @(negedge clk);
        bus.loc_ramaddress = 15'd9; bus.loc_ramwrite = 1'b1;
        bus.loc_writedata = 32'hDEAD_BEEF; bus.loc_ramclk = 1'b1;
        sample_valid = 1'b1; sample_data = 16'h7777;
        #1;
        n_checks++; if (sample_ready !== 1'b0) $display("FAIL coll_ready: %b, required 0", sample_ready); else n_pass++;
        @(negedge clk);
        bus.loc_ramclk = 1'b0; bus.loc_ramwrite = 1'b0; sample_valid = 1'b0;
        n_checks++; if (overrun !== 1'b1) $display("FAIL coll_overrun: %b, required 1", overrun); else n_pass++;
        n_checks++; if (wr_ptr !== 15'd8) $display("FAIL coll_wr_ptr: %0d, required 8", wr_ptr); else n_pass++;
        n_checks++; if (sample_ready !== 1'b1) $display("FAIL coll_ready_back: %b, required 1", sample_ready); else n_pass++;
        ring_addr_q.push_back(15'd9); ring_data_q.push_back(32'hDEAD_BEEF);
        ring_addr_q.push_back(15'd8); ring_data_q.push_back(32'h2222);
        check_ring_q("coll_ring");
        host_write(3'd7, 32'h0);
        n_checks++; if (overrun !== 1'b0) $display("FAIL clr_overrun: %b, required 0", overrun); else n_pass++;
    endtask

    task automatic test_bad_bounds();
        host_write(3'd0, {15'd12, 15'd20, 2'b00});
        n_checks++; if (wr_ptr !== 15'd7) $display("FAIL bad_reload: %0d, required 7", wr_ptr); else n_pass++;
        for (int k = 0; k < 1024; k++) begin
            @(negedge clk);
            if (k == 1023) begin
                n_checks++; if (wr_ptr !== 15'd1030) $display("FAIL bad_last: %0d, required 1030", wr_ptr); else n_pass++;
            end
            sample_valid = 1'b1; sample_data = 16'(k + 16'h2000);
            if (k == 0 || k == 1 || k == 13 || k == 1022 || k == 1023) begin
                ring_addr_q.push_back(15'(7 + k));
                ring_data_q.push_back({16'h0, 16'(k + 16'h2000)});
            end
        end
        @(negedge clk);
        sample_valid = 1'b0;
        n_checks++; if (wr_ptr !== 15'd7) $display("FAIL bad_wrap: %0d, required 7", wr_ptr); else n_pass++;
        check_ring_q("bad_ring");
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        bus.loc_ramaddress = 15'd100; bus.loc_ramwrite = 1'b1;
        bus.loc_writedata = 32'h1234_5678; bus.loc_ramclk = 1'b1;
        sample_valid = 1'b1; sample_data = 16'h0BAD;
        @(negedge clk);
        bus.loc_ramclk = 1'b0; bus.loc_ramwrite = 1'b0;
        sample_data = 16'h0C00;
        repeat (3) @(posedge clk);
        #2;
        n_checks++; if (wr_ptr !== 15'd10 || overrun !== 1'b1)
            $display("FAIL pre_rst: wr_ptr=%0d overrun=%b, required 10/1", wr_ptr, overrun); else n_pass++;
        bus.loc_ramaddress = 15'd1; bus.loc_ramread = 1'b1;
        reset = 1'b1;
        #1;
        n_checks++; if (wr_ptr !== 15'd7) $display("FAIL arst_wr_ptr: %0d, required 7", wr_ptr); else n_pass++;
        n_checks++; if (sample_ready !== 1'b0) $display("FAIL arst_ready: %b, required 0", sample_ready); else n_pass++;
        n_checks++; if (overrun !== 1'b0) $display("FAIL arst_overrun: %b, required 0", overrun); else n_pass++;
        n_checks++; if (out_sample !== 16'h0 || out_valid !== 1'b0)
            $display("FAIL arst_out: sample=%h valid=%b, required 0000/0", out_sample, out_valid); else n_pass++;
        n_checks++; if (bus.loc_readdata !== 32'h0) $display("FAIL arst_cfg1: %h, required 0", bus.loc_readdata); else n_pass++;
        bus.loc_ramread = 1'b0;
        @(negedge clk);
        sample_valid = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (wr_ptr !== 15'd7) $display("FAIL post_rst_wr_ptr: %0d, required 7", wr_ptr); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_cfg_read();
        test_ring_wrap();
        test_out_write();
        test_collision();
        test_bad_bounds();
        test_async_reset();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
